// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - debounce, one-shot press events, fixed-priority arbitration, event FIFO
// Optional auto-repeat while held is enabled by defining BUTTON_AUTO_REPEAT_EN.
module button_event_ctrl #(
    parameter int N_BTN      = 4,
    parameter int DB_LEN     = 5,
    parameter int HOLD_CYC   = 16,
    parameter int REPEAT_CYC = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         pb,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(N_BTN)-1:0] ev_code,
    output logic                     ev_repeat,
    output logic [N_BTN-1:0]         held,
    output logic                     overflow
);
    localparam int CW = $clog2(N_BTN);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int EW = CW + 1;
`else
    localparam int EW = CW;
`endif

    logic [DB_LEN-1:0] sr_q [N_BTN];
    logic [N_BTN-1:0]  held_dly_q;
    logic [N_BTN-1:0]  rise;
    logic [N_BTN-1:0]  press_pend_q, press_pend_d, press_clr;
    logic [N_BTN-1:0]  req;
    logic              overflow_q, overflow_d;
    logic              sel_found;
    logic [CW-1:0]     sel_idx;
    logic              push, pop, full, empty;
    logic [EW-1:0]     entry, head;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       cnt_q;

    always_comb begin
        for (int i = 0; i < N_BTN; i++) held[i] = &sr_q[i];
    end
    assign rise = held & ~held_dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) sr_q[i] <= '0;
            held_dly_q   <= '0;
            press_pend_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) sr_q[i] <= {sr_q[i][DB_LEN-2:0], pb[i]};
            held_dly_q   <= held;
            press_pend_q <= press_pend_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] HOLD_V = RW'(HOLD_CYC);
    localparam logic [RW-1:0] REP_V  = RW'(REPEAT_CYC);

    logic [RW-1:0]    hcnt_q [N_BTN];
    logic [N_BTN-1:0] started_q, tick;
    logic [N_BTN-1:0] rep_pend_q, rep_pend_d, rep_clr;
    logic             sel_rep;

    // hcnt counts held cycles; the first tick lands HOLD_CYC after the press edge, later ones every REPEAT_CYC
    always_comb begin
        for (int i = 0; i < N_BTN; i++)
            tick[i] = held[i] && (hcnt_q[i] == (started_q[i] ? REP_V : HOLD_V));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) hcnt_q[i] <= '0;
            started_q  <= '0;
            rep_pend_q <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!held[i]) begin
                    hcnt_q[i]    <= '0;
                    started_q[i] <= 1'b0;
                end else if (tick[i]) begin
                    hcnt_q[i]    <= RW'(1);
                    started_q[i] <= 1'b1;
                end else begin
                    hcnt_q[i] <= hcnt_q[i] + RW'(1);
                end
            end
            rep_pend_q <= rep_pend_d;
        end
    end
    assign req = press_pend_q | rep_pend_q;
`else
    assign req = press_pend_q;
`endif

    // Lowest index wins; descending scan leaves the lowest requester selected
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
        sel_rep   = 1'b0;
`endif
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_found = 1'b1;
                sel_idx   = CW'(i);
`ifdef BUTTON_AUTO_REPEAT_EN
                sel_rep   = ~press_pend_q[i];
`endif
            end
        end
    end

    assign pop  = ev_valid & ev_ready;
    assign push = sel_found & (~full | pop);

    always_comb begin
        press_clr  = '0;
        overflow_d = overflow_q;
`ifdef BUTTON_AUTO_REPEAT_EN
        rep_clr = '0;
        entry   = {sel_rep, sel_idx};
        if (push && sel_rep) rep_clr[sel_idx] = 1'b1;
        else if (push)       press_clr[sel_idx] = 1'b1;
        rep_pend_d = (rep_pend_q & ~rep_clr) | tick;
        if (|(tick & rep_pend_q & ~rep_clr)) overflow_d = 1'b1;
`else
        entry = sel_idx;
        if (push) press_clr[sel_idx] = 1'b1;
`endif
        press_pend_d = (press_pend_q & ~press_clr) | rise;
        if (|(rise & press_pend_q & ~press_clr)) overflow_d = 1'b1;
    end

    assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head     = empty ? '0 : mem_q[rd_q];
    assign ev_valid = ~empty;
    assign ev_code  = head[CW-1:0];
`ifdef BUTTON_AUTO_REPEAT_EN
    assign ev_repeat = head[CW];
`else
    assign ev_repeat = 1'b0;
`endif
    assign overflow = overflow_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - directed self-checking bench for button_event_ctrl
module tb_button_event_ctrl;
    localparam int N_BTN = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int  EXP_HOLD_EVENTS = 2;
    localparam logic EXP_HOLD_REP   = 1'b1;
`else
    localparam int  EXP_HOLD_EVENTS = 0;
    localparam logic EXP_HOLD_REP   = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] pb;
    logic             ev_valid, ev_ready, ev_repeat, overflow;
    logic [1:0]       ev_code;
    logic [N_BTN-1:0] held;

    int checks   = 0;
    int failures = 0;

    button_event_ctrl #(
        .N_BTN(4), .DB_LEN(5), .HOLD_CYC(16), .REPEAT_CYC(8), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .pb(pb),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_repeat(ev_repeat), .held(held), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic       seen_v, seen_h;
        int         n_ev, n_bad;
        logic [1:0] exp_codes [5];

        rst = 1'b1; pb = '0; ev_ready = 1'b0;
        step(3);
        check("rst_valid", 32'(ev_valid), 0);
        check("rst_code", 32'(ev_code), 0);
        check("rst_repeat", 32'(ev_repeat), 0);
        check("rst_held", 32'(held), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst = 1'b0;

        // glitch of DB_LEN-1 samples must not register
        seen_v = 1'b0; seen_h = 1'b0;
        pb = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) pb = '0;
            step(1);
            if (ev_valid) seen_v = 1'b1;
            if (|held)    seen_h = 1'b1;
        end
        check("glitch_valid", 32'(seen_v), 0);
        check("glitch_held", 32'(seen_h), 0);

        // single press on button 2, consumer always ready
        ev_ready = 1'b1;
        pb = 4'b0100;
        step(4);
        check("sp_held_e4", 32'(held), 32'h0);
        step(1);
        check("sp_held_e5", 32'(held), 32'h4);
        step(1);
        check("sp_valid_e6", 32'(ev_valid), 0);
        step(1);
        check("sp_valid_e7", 32'(ev_valid), 1);
        check("sp_code_e7", 32'(ev_code), 2);
        check("sp_repeat_e7", 32'(ev_repeat), 0);
        step(1);
        check("sp_valid_e8", 32'(ev_valid), 0);
        n_ev = 0; n_bad = 0;
        for (int i = 0; i < 29; i++) begin
            step(1);
            if (ev_valid) begin
                n_ev++;
                if (ev_code != 2'd2 || ev_repeat != EXP_HOLD_REP) n_bad++;
            end
        end
        check("sp_hold_events", 32'(n_ev), 32'(EXP_HOLD_EVENTS));
        check("sp_hold_bad", 32'(n_bad), 0);
        pb = '0;
        step(15);
        check("sp_release_valid", 32'(ev_valid), 0);

        // simultaneous press of 0,1,3 with back-pressure
        rst = 1'b1; step(1); rst = 1'b0;
        ev_ready = 1'b0;
        pb = 4'b1011;
        step(7);
        check("sim_valid_e7", 32'(ev_valid), 1);
        check("sim_code_e7", 32'(ev_code), 0);
        step(3);
        check("sim_held", 32'(held), 32'hb);
        check("sim_code_e10", 32'(ev_code), 0);
        ev_ready = 1'b1;
        step(1);
        check("sim_code_pop1", 32'(ev_code), 1);
        step(1);
        check("sim_code_pop2", 32'(ev_code), 3);
        check("sim_valid_pop2", 32'(ev_valid), 1);
        step(1);
        check("sim_valid_pop3", 32'(ev_valid), 0);
        check("sim_code_empty", 32'(ev_code), 0);
        pb = '0;
        step(5);

        // overflow: fill the FIFO, one merged press pending, then a lost press
        rst = 1'b1; step(1); rst = 1'b0;
        ev_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            pb = 4'(1 << b);
            step(7);
            pb = '0;
            step(2);
        end
        check("ovf_full_valid", 32'(ev_valid), 1);
        check("ovf_full_code", 32'(ev_code), 0);
        pb = 4'b0001; step(7); pb = '0; step(2);
        check("ovf_pending_only", 32'(overflow), 0);
        pb = 4'b0001; step(7); pb = '0; step(2);
        check("ovf_set", 32'(overflow), 1);
        exp_codes = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        ev_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("ovf_pop%0d_valid", k), 32'(ev_valid), 1);
            check($sformatf("ovf_pop%0d_code", k), 32'(ev_code), 32'(exp_codes[k]));
            step(1);
        end
        check("ovf_drained", 32'(ev_valid), 0);
        check("ovf_sticky", 32'(overflow), 1);
        rst = 1'b1; step(1); rst = 1'b0;
        check("ovf_rst_clear", 32'(overflow), 0);

        // reset while a press is queued and the button stays held
        ev_ready = 1'b0;
        pb = 4'b0001;
        step(8);
        check("rmh_queued", 32'(ev_valid), 1);
        rst = 1'b1; step(1); rst = 1'b0;
        check("rmh_rst_valid", 32'(ev_valid), 0);
        check("rmh_rst_held", 32'(held), 0);
        step(6);
        check("rmh_valid_e6", 32'(ev_valid), 0);
        step(1);
        check("rmh_valid_e7", 32'(ev_valid), 1);
        check("rmh_code_e7", 32'(ev_code), 0);
        check("rmh_repeat_e7", 32'(ev_repeat), 0);
        pb = '0;
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
